updown_counter_param: RTL

- Parametrised synchronous up/down counter. Successor to the fixed 3-bit up/down counter block.
- Generalised in width and modulus. Adds count enable, parallel load, and a wrap/saturate mode.
- Adds terminal-count and wrap-event status outputs.
- Used as a general sequencer and index counter by datapath and control blocks.

---
 rtl/updown_counter_param_pkg.sv | 20 ++
 rtl/updown_counter_param_step.sv | 54 +++++
 rtl/updown_counter_param.sv | 91 +++++++++
 3 files changed

// File: rtl/updown_counter_param_pkg.sv
// Shared constants for the parametrised up/down counter.
//
// Contents:
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter
//   DIR_DOWN  / DIR_UP   : encodings of the 'up' direction input
//   max_for_width()      : largest value representable in a given width
package updown_counter_param_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // 64-bit arithmetic so that WIDTH = 32 does not overflow.
    function automatic longint unsigned max_for_width(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/updown_counter_param_step.sv
// Combinational single-step logic for the up/down counter.
//
// Computes the value one enabled step away from q_i, and flags whether that
// step crosses a range end and wraps around.
//
// Parameters:
//   WIDTH    : counter width in bits
//   MAX_VAL  : highest count value (range is 0..MAX_VAL)
//   SATURATE : MODE_WRAP wraps at the ends, MODE_SAT holds there
// Ports:
//   q_i        : current count
//   up_i       : direction (DIR_UP increments, DIR_DOWN decrements)
//   next_q_o   : count after one enabled step
//   wrap_evt_o : high when this step wraps around a range end
module updown_step
    import updown_counter_param_pkg::*;
#(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter bit               SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] next_q_o,
    output logic             wrap_evt_o
);

    // Boundaries come from explicit compares; MAX_VAL need not be a power
    // of two minus one, so natural overflow cannot be used for wrapping.
    always_comb begin
        next_q_o   = q_i;
        wrap_evt_o = 1'b0;
        if (up_i == DIR_UP) begin
            if (q_i == MAX_VAL) begin
                if (SATURATE == MODE_WRAP) begin
                    next_q_o   = '0;
                    wrap_evt_o = 1'b1;
                end
            end else begin
                next_q_o = q_i + WIDTH'(1);
            end
        end else begin
            if (q_i == '0) begin
                if (SATURATE == MODE_WRAP) begin
                    next_q_o   = MAX_VAL;
                    wrap_evt_o = 1'b1;
                end
            end else begin
                next_q_o = q_i - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with enable, parallel load,
// wrap/saturate mode, terminal-count and wrap-event status.
//
// Parameters:
//   WIDTH    : counter width, 1..32
//   MAX_VAL  : highest count value, 1..2**WIDTH-1
//   SATURATE : MODE_WRAP (0) wraps at the ends, MODE_SAT (1) holds there
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   en       : count enable, one step per cycle
//   up       : direction, 1 = increment, 0 = decrement
//   load     : parallel load strobe (overrides en/up)
//   load_val : value to load, clamped to MAX_VAL
//   q        : registered count
//   tc       : combinational terminal count (next enabled edge hits a boundary)
//   wrap     : registered one-cycle pulse after a wrap-around edge
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int              WIDTH    = 3,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be in 1..32");
    end

    if (MAX_VAL == 64'd0 || MAX_VAL > max_for_width(WIDTH)) begin : g_bad_max
        $error("updown_counter_param: MAX_VAL must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_q;
    logic             step_wrap;

    updown_step #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_Q),
        .SATURATE (SATURATE)
    ) u_step (
        .q_i        (count_q),
        .up_i       (up),
        .next_q_o   (step_q),
        .wrap_evt_o (step_wrap)
    );

    // Priority: load > en; reset is applied in the register itself.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (en) begin
            count_d = step_q;
            wrap_d  = step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Independent of load and SATURATE: only looks at where the next
    // enabled step would go.
    assign tc   = en & (((up == DIR_UP)   & (count_q == MAX_Q)) |
                        ((up == DIR_DOWN) & (count_q == '0)));
    assign q    = count_q;
    assign wrap = wrap_q;

endmodule
